// File: rtl/alu_op_sequencer.sv
// Pulls operand A, operand B and an opcode from a FWFT receive FIFO, latches the ALU result
// and hands it to the transmit side. Define ALU_SEQ_ASCII_IN_EN to take ASCII-digit operands.
module alu_op_sequencer #(
    parameter int unsigned NBIT = 8,
    parameter int unsigned NOP  = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            rx_empty,
    input  logic [NBIT-1:0] rx_data,
    output logic            RD_FIFO,
    input  logic [NBIT-1:0] alu_result,
    output logic [NBIT-1:0] A_OUT,
    output logic [NBIT-1:0] B_OUT,
    output logic [NOP-1:0]  OP_OUT,
    output logic [NBIT-1:0] RES_OUT,
    input  logic            tx_idle,
    output logic            ENVIAR,
    output logic [7:0]      OP_COUNT,
    output logic [2:0]      STATE
);

    typedef enum logic [2:0] {
        StA    = 3'd0,
        StB    = 3'd1,
        StOp   = 3'd2,
        StExec = 3'd3,
        StSend = 3'd4
    } state_e;

    state_e          state_q;
    logic [NBIT-1:0] operand;

    always_comb begin
`ifdef ALU_SEQ_ASCII_IN_EN
        operand = rx_data - NBIT'(48);
`else
        operand = rx_data;
`endif
    end

    // Strobes are gated by RESET so they read 0 while reset is held, not just after it.
    always_comb begin
        RD_FIFO = 1'b0;
        ENVIAR  = 1'b0;
        if (!RESET) begin
            case (state_q)
                StA, StB, StOp: RD_FIFO = !rx_empty;
                StSend:         ENVIAR  = tx_idle;
                default:        ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StA;
            A_OUT    <= '0;
            B_OUT    <= '0;
            OP_OUT   <= '0;
            RES_OUT  <= '0;
            OP_COUNT <= 8'd0;
        end else begin
            case (state_q)
                StA: begin
                    if (!rx_empty) begin
                        A_OUT   <= operand;
                        state_q <= StB;
                    end
                end
                StB: begin
                    if (!rx_empty) begin
                        B_OUT   <= operand;
                        state_q <= StOp;
                    end
                end
                StOp: begin
                    if (!rx_empty) begin
                        OP_OUT  <= rx_data[NOP-1:0];
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    RES_OUT <= alu_result;
                    state_q <= StSend;
                end
                StSend: begin
                    if (tx_idle) begin
                        OP_COUNT <= OP_COUNT + 8'd1;
                        state_q  <= StA;
                    end
                end
                default: state_q <= StA;
            endcase
        end
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, directed corner cases and a
// randomized run scored against a transaction-level model of the operation stream.
module tb_alu_op_sequencer;

    localparam int unsigned NBIT = 8;
    localparam int unsigned NOP  = 6;

    logic            CLK;
    logic            RESET;
    logic            rx_empty;
    logic [NBIT-1:0] rx_data;
    logic            RD_FIFO;
    logic [NBIT-1:0] alu_result;
    logic [NBIT-1:0] A_OUT;
    logic [NBIT-1:0] B_OUT;
    logic [NOP-1:0]  OP_OUT;
    logic [NBIT-1:0] RES_OUT;
    logic            tx_idle;
    logic            ENVIAR;
    logic [7:0]      OP_COUNT;
    logic [2:0]      STATE;

    alu_op_sequencer #(.NBIT(NBIT), .NOP(NOP)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .RD_FIFO    (RD_FIFO),
        .alu_result (alu_result),
        .A_OUT      (A_OUT),
        .B_OUT      (B_OUT),
        .OP_OUT     (OP_OUT),
        .RES_OUT    (RES_OUT),
        .tx_idle    (tx_idle),
        .ENVIAR     (ENVIAR),
        .OP_COUNT   (OP_COUNT),
        .STATE      (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Environment ALU: opcode low bits select add / sub / xor / and.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result = alu_f(A_OUT, B_OUT, OP_OUT);

    function automatic logic [7:0] operand_f(input logic [7:0] x);
`ifdef ALU_SEQ_ASCII_IN_EN
        return x - 8'd48;
`else
        return x;
`endif
    endfunction

    function automatic logic [7:0] enc_f(input logic [7:0] v);
`ifdef ALU_SEQ_ASCII_IN_EN
        return v + 8'd48;
`else
        return v;
`endif
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [5:0] op_out;
        logic [7:0] res;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int phase = 0;
    int third_cyc = 0;
    int sent = 0;
    int env_count = 0;
    bit lat_check = 1'b0;
    bit rand_mode = 1'b0;
    bit hold_empty = 1'b0;
    logic last_rd;
    logic last_en;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic [7:0] fifo[$];
    logic [7:0] exp_res[$];
    int pop_cycs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic drive();
        rx_empty = hold_empty || (fifo.size() == 0);
        rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        fifo.push_back(a);
        fifo.push_back(b);
        fifo.push_back(op);
        drive();
    endtask

    task automatic model_clear();
        phase = 0;
        sent = 0;
        exp_res.delete();
        fifo.delete();
        pop_cycs.delete();
        drive();
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd_fifo", 32'(RD_FIFO), 32'd0);
        chk("rst_enviar", 32'(ENVIAR), 32'd0);
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_a_out", 32'(A_OUT), 32'd0);
        chk("rst_b_out", 32'(B_OUT), 32'd0);
        chk("rst_op_out", 32'(OP_OUT), 32'd0);
        chk("rst_res_out", 32'(RES_OUT), 32'd0);
        chk("rst_op_count", 32'(OP_COUNT), 32'd0);
    endtask

    // One clock: sample at negedge, score against the model, drive new inputs after posedge.
    task automatic tick();
        logic [7:0] b;
        int cap_phase;
        @(negedge CLK);
        last_rd = RD_FIFO;
        last_en = ENVIAR;
        b = rx_data;
        cap_phase = phase;
        chk("strobe_exclusive", 32'(last_rd & last_en), 32'd0);
        if (last_rd) chk("pop_when_empty", 32'(rx_empty), 32'd0);
        if (last_en) begin
            chk("pending_op_at_send", 32'(exp_res.size() > 0), 32'd1);
            if (exp_res.size() > 0) chk("res_out", 32'(RES_OUT), 32'(exp_res.pop_front()));
            if (lat_check) chk("pop_to_send_latency", cyc - third_cyc, 32'd2);
        end
        if (last_rd) begin
            pop_cycs.push_back(cyc);
            case (phase)
                0: a_byte = b;
                1: b_byte = b;
                default: begin
                    exp_res.push_back(alu_f(operand_f(a_byte), operand_f(b_byte), b[5:0]));
                    third_cyc = cyc;
                end
            endcase
            phase = (phase + 1) % 3;
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (last_rd) begin
            case (cap_phase)
                0:       chk("a_capture", 32'(A_OUT), 32'(operand_f(b)));
                1:       chk("b_capture", 32'(B_OUT), 32'(operand_f(b)));
                default: chk("op_capture", 32'(OP_OUT), 32'(b[5:0]));
            endcase
            void'(fifo.pop_front());
        end
        if (last_en) begin
            sent++;
            env_count++;
            chk("op_count", 32'(OP_COUNT), 32'(sent % 256));
        end
        if (rand_mode) begin
            if (fifo.size() < 3 && $urandom_range(3) != 0) fifo.push_back(8'($urandom_range(255)));
            hold_empty = ($urandom_range(4) == 0);
            tx_idle = ($urandom_range(3) != 0);
        end
        drive();
    endtask

    task automatic run_until_env(input int budget);
        int start = env_count;
        int n = 0;
        while (env_count == start && n < budget) begin
            tick();
            n++;
        end
        chk("enviar_within_budget", 32'(env_count != start), 32'd1);
    endtask

    task automatic run_until_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (STATE != s && n < budget) begin
            tick();
            n++;
        end
        chk("state_within_budget", 32'(STATE), 32'(s));
    endtask

    initial begin
        vec_t tbl[6];
        int start;
        tbl[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, op_out: 6'h20, res: 8'h08};
        tbl[1] = '{a: 8'h03, b: 8'h04, op: 8'h20, op_out: 6'h20, res: 8'h07};
        tbl[2] = '{a: 8'hC8, b: 8'h64, op: 8'hE1, op_out: 6'h21, res: 8'h64};
        tbl[3] = '{a: 8'hF0, b: 8'h3C, op: 8'h02, op_out: 6'h02, res: 8'hCC};
        tbl[4] = '{a: 8'hF0, b: 8'h3C, op: 8'h3F, op_out: 6'h3F, res: 8'h30};
        tbl[5] = '{a: 8'hFF, b: 8'h01, op: 8'h40, op_out: 6'h00, res: 8'h00};

        // Reset with data waiting: nothing may be popped while RESET is high.
        RESET = 1'b1;
        tx_idle = 1'b1;
        fifo.push_back(8'h11);
        drive();
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Basic operation: three consecutive pops, send two cycles after the last.
        lat_check = 1'b1;
        push3(enc_f(8'h05), enc_f(8'h03), 8'h20);
        run_until_env(20);
        chk("three_pops", 32'(pop_cycs.size()), 32'd3);
        if (pop_cycs.size() == 3) chk("pops_consecutive", pop_cycs[2] - pop_cycs[0], 32'd2);
        chk("basic_res", 32'(RES_OUT), 32'h08);
        chk("basic_count", 32'(OP_COUNT), 32'd1);

        for (int i = 0; i < 6; i++) begin
            push3(enc_f(tbl[i].a), enc_f(tbl[i].b), tbl[i].op);
            run_until_env(20);
            chk("tbl_a_out", 32'(A_OUT), 32'(tbl[i].a));
            chk("tbl_b_out", 32'(B_OUT), 32'(tbl[i].b));
            chk("tbl_op_out", 32'(OP_OUT), 32'(tbl[i].op_out));
            chk("tbl_res_out", 32'(RES_OUT), 32'(tbl[i].res));
        end

`ifdef ALU_SEQ_ASCII_IN_EN
        push3(8'h33, 8'h34, 8'h20);
        run_until_env(20);
        chk("ascii_a", 32'(A_OUT), 32'd3);
        chk("ascii_b", 32'(B_OUT), 32'd4);
        chk("ascii_res", 32'(RES_OUT), 32'd7);
`endif

        // Transmitter busy in S_SEND with a full FIFO: hold, no pops, then one send.
        lat_check = 1'b0;
        tx_idle = 1'b0;
        push3(enc_f(8'h21), enc_f(8'h12), 8'h00);
        run_until_state(3'd4, 20);
        push3(enc_f(8'h01), enc_f(8'h02), 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_state", 32'(STATE), 32'd4);
            chk("busy_enviar", 32'(last_en), 32'd0);
            chk("busy_rd_fifo", 32'(last_rd), 32'd0);
        end
        tx_idle = 1'b1;
        start = env_count;
        for (int i = 0; i < 3; i++) tick();
        chk("single_send", env_count - start, 32'd1);
        lat_check = 1'b1;
        run_until_env(20);

        // FIFO runs dry between A and B.
        fifo.push_back(enc_f(8'h07));
        drive();
        run_until_state(3'd1, 10);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("starve_state", 32'(STATE), 32'd1);
            chk("starve_rd_fifo", 32'(last_rd), 32'd0);
        end
        fifo.push_back(enc_f(8'h09));
        fifo.push_back(8'h00);
        drive();
        run_until_env(20);
        chk("starve_res", 32'(RES_OUT), 32'h10);

        // Reset in S_OP after A and B captured: operation is dropped.
        fifo.push_back(enc_f(8'h04));
        fifo.push_back(enc_f(8'h04));
        drive();
        run_until_state(3'd2, 10);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_outputs();
        model_clear();
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        start = env_count;
        for (int i = 0; i < 5; i++) tick();
        chk("no_send_after_abort", env_count - start, 32'd0);
        push3(enc_f(8'h02), enc_f(8'h02), 8'h00);
        run_until_env(20);
        chk("post_abort_res", 32'(RES_OUT), 32'h04);

        // Randomized stream until the operation counter has wrapped.
        lat_check = 1'b0;
        rand_mode = 1'b1;
        while (sent < 256 && cyc < 20000) tick();
        rand_mode = 1'b0;
        chk("reached_256_ops", sent, 32'd256);
        chk("op_count_wrapped", 32'(OP_COUNT), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
